if_stage: RTL and testbench

Instruction fetch stage of the pipelined RV32I core. Holds the PC, fetches one instruction at a time from instruction memory over a request/response handshake, and presents it in the IF/ID pipeline register. The control unit decodes the opcode field of `if_id_inst`. Branch/JAL/JALR resolution redirects the stage, and the hazard unit stalls it.

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem fetch,
// skid buffer and IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        drop_q, drop_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc4_q, ipc4_d;
    logic [31:0] inst_q, inst_d;
    logic        ifid_free;

    assign imem_req    = (state_q == S_REQ) & ~redirect;
    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = ipc_q;
    assign if_id_pc4   = ipc4_q;
    assign if_id_inst  = inst_q;

    // Next-state: fetch FSM, IF/ID handoff, redirect override last
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        drop_d      = drop_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        valid_d     = valid_q;
        ipc_d       = ipc_q;
        inst_d      = inst_q;
        ifid_free   = ~valid_q | ~stall;

        if (valid_q & ~stall) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end

        unique case (state_q)
            S_REQ: begin
                if (imem_req & imem_ready) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    if (drop_q) begin
                        drop_d = 1'b0;
                    end else if (ifid_free) begin
                        valid_d = 1'b1;
                        ipc_d   = fetch_pc_q;
                        inst_d  = imem_rdata;
                    end else begin
                        skid_pc_d   = fetch_pc_q;
                        skid_inst_d = imem_rdata;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (~stall) begin
                    valid_d = 1'b1;
                    ipc_d   = skid_pc_q;
                    inst_d  = skid_inst_q;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            pc_d        = {redirect_pc[31:2], 2'b00};
            valid_d     = 1'b0;
            ipc_d       = 32'd0;
            inst_d      = NOP_INST;
            skid_pc_d   = 32'd0;
            skid_inst_d = 32'd0;
            if ((state_q == S_WAIT) & ~imem_rvalid) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end else begin
                drop_d  = 1'b0;
                state_d = S_REQ;
            end
        end

        ipc4_d = ipc_d + 32'd4;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= {RESET_PC[31:2], 2'b00};
            fetch_pc_q  <= 32'd0;
            drop_q      <= 1'b0;
            skid_inst_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            valid_q     <= 1'b0;
            ipc_q       <= 32'd0;
            ipc4_q      <= 32'd4;
            inst_q      <= NOP_INST;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_q      <= drop_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            valid_q     <= valid_d;
            ipc_q       <= ipc_d;
            ipc4_q      <= ipc4_d;
            inst_q      <= inst_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, then random traffic
// checked against an in-order transaction model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, w_req;
    logic [31:0] imem_addr, w_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid, w_valid;
    logic [31:0] if_id_pc, w_pc;
    logic [31:0] if_id_pc4, w_pc4;
    logic [31:0] if_id_inst, w_inst;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc;
    logic [31:0] oaddr;
    bit          outst;
    bit          stale;

    always #5 clk = ~clk;

    if_stage u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .if_id_valid(if_id_valid),
        .if_id_pc   (if_id_pc),
        .if_id_pc4  (if_id_pc4),
        .if_id_inst (if_id_inst)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (w_req),
        .imem_addr  (w_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .stall      (stall),
        .if_id_valid(w_valid),
        .if_id_pc   (w_pc),
        .if_id_pc4  (w_pc4),
        .if_id_inst (w_inst)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_ifid(input logic v, input logic [31:0] pc,
                            input logic [31:0] inst);
        chk("ifid_valid", {31'd0, if_id_valid}, {31'd0, v});
        if (v) begin
            chk("ifid_pc", if_id_pc, pc);
            chk("ifid_pc4", if_id_pc4, pc + 32'd4);
            chk("ifid_inst", if_id_inst, inst);
        end else begin
            chk("ifid_nop", if_id_inst, NOP);
        end
    endtask

    task automatic rcycle(input bit quiet);
        bit rv;
        bit was_outst;
        if (q.size() > 0) chk_ifid(1'b1, q[0].pc, q[0].inst);
        else chk_ifid(1'b0, 32'd0, 32'd0);
        if (quiet) begin
            stall       = 1'b0;
            redirect    = 1'b0;
            imem_ready  = 1'b1;
            imem_rvalid = outst;
        end else begin
            stall       = ($urandom_range(0, 9) < 3);
            redirect    = ($urandom_range(0, 19) == 0);
            imem_ready  = ($urandom_range(0, 9) < 7);
            imem_rvalid = outst ? ($urandom_range(0, 1) == 1)
                                : ($urandom_range(0, 9) == 0);
        end
        imem_rdata  = $urandom;
        redirect_pc = $urandom;
        #1;
        if (redirect) chk("req_redirect", {31'd0, imem_req}, 32'd0);
        if (imem_req) chk("imem_addr", imem_addr, mpc);
        was_outst = outst;
        rv = imem_rvalid & outst;
        if (redirect) begin
            q.delete();
            stale = outst;
            mpc = {redirect_pc[31:2], 2'b00};
        end else if (q.size() > 0 && !stall) begin
            void'(q.pop_front());
        end
        if (rv) begin
            if (!stale) q.push_back('{oaddr, imem_rdata});
            outst = 1'b0;
            stale = 1'b0;
        end
        if (imem_req && imem_ready) begin
            chk("one_outstanding", {31'd0, was_outst}, 32'd0);
            oaddr = mpc;
            mpc   = mpc + 32'd4;
            outst = 1'b1;
            stale = 1'b0;
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;
        redirect = 1'b0;
        redirect_pc = 32'd0;
        stall = 1'b0;
        tick();
        tick();
        // reset state
        chk_ifid(1'b0, 32'd0, 32'd0);
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc4, 32'd4);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'd0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        tick();
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h11;
        tick();
        imem_rvalid = 1'b0;
        chk_ifid(1'b1, 32'd0, 32'h11);
        chk("wrap_addr1", w_addr, 32'd0);
        chk("addr4", imem_addr, 32'd4);
        tick();
        chk_ifid(1'b0, 32'd0, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h22;
        tick();
        imem_rvalid = 1'b0;
        chk_ifid(1'b1, 32'd4, 32'h22);
        // stall with IF/ID valid; response goes to skid
        stall = 1'b1;
        tick();
        chk_ifid(1'b1, 32'd4, 32'h22);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h33;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_ifid(1'b1, 32'd4, 32'h22);
            chk("hold_req", {31'd0, imem_req}, 32'd0);
            tick();
        end
        chk_ifid(1'b1, 32'd4, 32'h22);
        stall = 1'b0;
        tick();
        chk_ifid(1'b1, 32'd8, 32'h33);
        chk("addr12", imem_addr, 32'd12);
        tick();
        chk_ifid(1'b0, 32'd0, 32'd0);
        // redirect in S_WAIT, late stale response
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk_ifid(1'b0, 32'd0, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        chk_ifid(1'b0, 32'd0, 32'd0);
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, 32'h100);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hABC;
        tick();
        imem_rvalid = 1'b0;
        chk_ifid(1'b1, 32'h100, 32'hABC);
        // redirect + stall together, unaligned target
        stall = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h203;
        #1;
        chk("rs_req", {31'd0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        stall = 1'b0;
        chk_ifid(1'b0, 32'd0, 32'd0);
        chk("rs_pc", if_id_pc, 32'd0);
        chk("rs_pc4", if_id_pc4, 32'd4);
        chk("align_addr", imem_addr, 32'h200);
        // reset while waiting, stale rvalid after release
        tick();
        rst_n = 1'b0;
        imem_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD;
        chk("post_rst_addr", imem_addr, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        chk_ifid(1'b0, 32'd0, 32'd0);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr2", imem_addr, 32'd0);
        imem_ready = 1'b1;
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'h77;
        tick();
        imem_rvalid = 1'b0;
        chk_ifid(1'b1, 32'd0, 32'h77);
        // random traffic against the transaction model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        q.delete();
        mpc = 32'd0;
        oaddr = 32'd0;
        outst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 3000; i++) rcycle(1'b0);
        for (int i = 0; i < 20; i++) rcycle(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
